// File: rtl/pong_pkg.sv
// Shared pong definitions: PS/2 make codes, paddle controller states and the
// default screen/paddle geometry used by both the controller and the renderer.
package pong_pkg;

  localparam int DEF_SCREEN_H    = 480;
  localparam int DEF_PADDLE_H    = 64;
  localparam int DEF_STEP_SLOW   = 4;
  localparam int DEF_STEP_FAST   = 8;
  localparam int DEF_RAMP_FRAMES = 8;
  localparam int DEF_Y_W         = 10;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_I     = 8'h43;
  localparam logic [7:0] KEY_K     = 8'h42;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_P     = 8'h4D;
  localparam logic [7:0] KEY_ESC   = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MOVE_SLOW = 2'd1,
    ST_MOVE_FAST = 2'd2,
    ST_PAUSED    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/paddle_axis.sv
// One paddle: position register with saturating up/down steps, a hold counter
// that ramps the step size, and a load-to-centre input.
module paddle_axis #(
  parameter int Y_W         = 10,
  parameter int Y_MAX       = 416,
  parameter int CENTER      = 208,
  parameter int STEP_SLOW   = 4,
  parameter int STEP_FAST   = 8,
  parameter int RAMP_FRAMES = 8,
  parameter int HOLD_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              up,
  input  logic              down,
  input  logic              clr,
  input  logic              center,
  output logic [Y_W-1:0]    y,
  output logic [HOLD_W-1:0] hold_cnt
);

  logic [Y_W-1:0]    y_q, y_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [Y_W:0]      step;
  logic [Y_W:0]      sum;

  always_comb begin
    // A clearing cycle counts as hold 0, so a fresh press always starts slow.
    step   = (!clr && hold_q >= HOLD_W'(RAMP_FRAMES)) ? (Y_W+1)'(STEP_FAST)
                                                      : (Y_W+1)'(STEP_SLOW);
    sum    = '0;
    y_d    = y_q;
    hold_d = hold_q;
    if (up) begin
      sum = {1'b0, y_q} - step;
      y_d = sum[Y_W] ? '0 : sum[Y_W-1:0];
    end else if (down) begin
      sum = {1'b0, y_q} + step;
      y_d = (sum > (Y_W+1)'(Y_MAX)) ? Y_W'(Y_MAX) : sum[Y_W-1:0];
    end
    if (clr) begin
      hold_d = '0;
    end else if ((up || down) && hold_q < HOLD_W'(RAMP_FRAMES)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
    if (center) begin
      y_d = Y_W'(CENTER);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q    <= Y_W'(CENTER);
      hold_q <= '0;
    end else begin
      y_q    <= y_d;
      hold_q <= hold_d;
    end
  end

  assign y        = y_q;
  assign hold_cnt = hold_q;

endmodule

// File: rtl/pong_paddle_ctrl.sv
// Keyboard-driven paddle controller: turns the PS/2 held-key state into two
// paddle positions stepped once per frame, plus serve/pause/re-centre events.
module pong_paddle_ctrl
  import pong_pkg::*;
#(
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int PADDLE_H    = DEF_PADDLE_H,
  parameter int STEP_SLOW   = DEF_STEP_SLOW,
  parameter int STEP_FAST   = DEF_STEP_FAST,
  parameter int RAMP_FRAMES = DEF_RAMP_FRAMES,
  parameter int Y_W         = DEF_Y_W
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ps2_state,
  input  logic [7:0]     ps2_byte,
  input  logic           frame_tick,
  output logic [Y_W-1:0] paddle_l_y,
  output logic [Y_W-1:0] paddle_r_y,
  output logic           paused,
  output logic           serve_req
);

  localparam int Y_MAX  = SCREEN_H - PADDLE_H;
  localparam int CENTER = Y_MAX / 2;
  localparam int HOLD_W = $clog2(RAMP_FRAMES + 1);

  logic        st_q, st_prev_q;
  logic [7:0]  byte_q, byte_prev_q;
  ctrl_state_t state_q, state_d;
  logic        paused_q, paused_d;
  logic        serve_q, serve_d;

  logic press, esc_press, p_press, space_press;
  logic key_w, key_s, key_i, key_k, move_key;
  logic move_tick, axis_clr;
  logic [HOLD_W-1:0] hold_l, hold_r, act_hold;

  always_comb begin
    press       = st_q && (!st_prev_q || (byte_q != byte_prev_q));
    esc_press   = press && (byte_q == KEY_ESC);
    p_press     = press && (byte_q == KEY_P);
    space_press = press && (byte_q == KEY_SPACE);
    key_w       = st_q && (byte_q == KEY_W);
    key_s       = st_q && (byte_q == KEY_S);
    key_i       = st_q && (byte_q == KEY_I);
    key_k       = st_q && (byte_q == KEY_K);
    move_key    = key_w || key_s || key_i || key_k;
    move_tick   = frame_tick && !paused_q && !esc_press;
    axis_clr    = press || !st_q || (frame_tick && paused_q);
    act_hold    = (key_w || key_s) ? hold_l : hold_r;
  end

  always_comb begin
    state_d = state_q;
    if (p_press) begin
      state_d = (state_q == ST_PAUSED) ? ST_IDLE : ST_PAUSED;
    end else if (esc_press) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_PAUSED) begin
      if (!move_key) begin
        state_d = ST_IDLE;
      end else if (press || state_q == ST_IDLE) begin
        state_d = ST_MOVE_SLOW;
      end else if (act_hold >= HOLD_W'(RAMP_FRAMES)) begin
        state_d = ST_MOVE_FAST;
      end
    end
    paused_d = (state_d == ST_PAUSED);
    serve_d  = space_press && !paused_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q        <= 1'b0;
      st_prev_q   <= 1'b0;
      byte_q      <= '0;
      byte_prev_q <= '0;
      state_q     <= ST_IDLE;
      paused_q    <= 1'b0;
      serve_q     <= 1'b0;
    end else begin
      st_q        <= ps2_state;
      st_prev_q   <= st_q;
      byte_q      <= ps2_byte;
      byte_prev_q <= byte_q;
      state_q     <= state_d;
      paused_q    <= paused_d;
      serve_q     <= serve_d;
    end
  end

  paddle_axis #(
    .Y_W(Y_W), .Y_MAX(Y_MAX), .CENTER(CENTER), .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST), .RAMP_FRAMES(RAMP_FRAMES), .HOLD_W(HOLD_W)
  ) u_axis_l (
    .clk(clk), .rst_n(rst_n),
    .up(move_tick && key_w), .down(move_tick && key_s),
    .clr(axis_clr), .center(esc_press),
    .y(paddle_l_y), .hold_cnt(hold_l)
  );

  paddle_axis #(
    .Y_W(Y_W), .Y_MAX(Y_MAX), .CENTER(CENTER), .STEP_SLOW(STEP_SLOW),
    .STEP_FAST(STEP_FAST), .RAMP_FRAMES(RAMP_FRAMES), .HOLD_W(HOLD_W)
  ) u_axis_r (
    .clk(clk), .rst_n(rst_n),
    .up(move_tick && key_i), .down(move_tick && key_k),
    .clr(axis_clr), .center(esc_press),
    .y(paddle_r_y), .hold_cnt(hold_r)
  );

  assign paused    = paused_q;
  assign serve_req = serve_q;

endmodule

// File: tb/tb_pong_paddle_ctrl.sv
// Bench for pong_paddle_ctrl: table of key-hold vectors plus hand sequences,
// with every cycle's expected outputs queued at drive time and checked after the edge.
module tb_pong_paddle_ctrl;

  localparam int CTR  = 208;
  localparam int YMAX = 416;
  localparam logic [7:0] K_W = 8'h1D, K_S = 8'h1B, K_I = 8'h43, K_K = 8'h42;
  localparam logic [7:0] K_SP = 8'h29, K_P = 8'h4D, K_ESC = 8'h76;

  logic       clk = 1'b0;
  logic       rst_n, ps2_state, frame_tick;
  logic [7:0] ps2_byte;
  logic [9:0] paddle_l_y, paddle_r_y;
  logic       paused, serve_req;

  always #10 clk = ~clk;

  pong_paddle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .ps2_state(ps2_state), .ps2_byte(ps2_byte),
    .frame_tick(frame_tick), .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y),
    .paused(paused), .serve_req(serve_req)
  );

  typedef struct {
    string name;
    int    due;
    int    l;
    int    r;
    bit    p;
    bit    s;
  } exp_t;

  typedef struct {
    string      name;
    logic [7:0] key;
    int         ticks;
    int         exp_l;
    int         exp_r;
  } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[7];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   m_l, m_r;
  bit   m_p;

  // Inputs change on the falling edge; expectations are due after the next rising edge.
  task automatic drive(input bit rn, input bit st, input logic [7:0] b, input bit t,
                       input string name, input bit s_exp);
    @(negedge clk);
    rst_n      = rn;
    ps2_state  = st;
    ps2_byte   = b;
    frame_tick = t;
    exp_q.push_back('{name, cyc + 1, m_l, m_r, m_p, s_exp});
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      mon_e = exp_q.pop_front();
      n_chk++;
      if (paddle_l_y !== 10'(mon_e.l) || paddle_r_y !== 10'(mon_e.r) ||
          paused !== mon_e.p || serve_req !== mon_e.s) begin
        n_err++;
        $display("FAIL %s cyc=%0d got l=%0d r=%0d p=%0b s=%0b want l=%0d r=%0d p=%0b s=%0b",
                 mon_e.name, cyc, paddle_l_y, paddle_r_y, paused, serve_req,
                 mon_e.l, mon_e.r, mon_e.p, mon_e.s);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"hold_w3",    K_W,   3,  196, 208};
    vecs[1] = '{"esc",        K_ESC, 0,  208, 208};
    vecs[2] = '{"hold_s40",   K_S,   40, 416, 208};
    vecs[3] = '{"junk_key",   8'h1C, 3,  416, 208};
    vecs[4] = '{"hold_i5",    K_I,   5,  416, 188};
    vecs[5] = '{"hold_k3",    K_K,   3,  416, 200};
    vecs[6] = '{"hold_w60",   K_W,   60, 0,   200};

    rst_n = 1'b0; ps2_state = 1'b0; ps2_byte = 8'h00; frame_tick = 1'b0;
    m_l = CTR; m_r = CTR; m_p = 1'b0;
    drive(0, 0, 8'h00, 0, "reset", 0);
    drive(0, 0, 8'h00, 0, "reset", 0);
    drive(1, 0, 8'h00, 0, "post_reset", 0);

    foreach (vecs[i]) begin
      drive(1, 1, vecs[i].key, 0, vecs[i].name, 0);
      if (vecs[i].key == K_ESC) begin
        m_l = CTR; m_r = CTR; m_p = 1'b0;
      end
      drive(1, 1, vecs[i].key, 0, vecs[i].name, 0);
      drive(1, 1, vecs[i].key, 0, vecs[i].name, 0);
      for (int t = 0; t < vecs[i].ticks; t++) begin
        int sz;
        sz = (t >= 8) ? 8 : 4;
        case (vecs[i].key)
          K_W:     m_l = (m_l - sz < 0) ? 0 : m_l - sz;
          K_S:     m_l = (m_l + sz > YMAX) ? YMAX : m_l + sz;
          K_I:     m_r = (m_r - sz < 0) ? 0 : m_r - sz;
          K_K:     m_r = (m_r + sz > YMAX) ? YMAX : m_r + sz;
          default: ;
        endcase
        if (t == vecs[i].ticks - 1) begin
          m_l = vecs[i].exp_l; m_r = vecs[i].exp_r;
        end
        drive(1, 1, vecs[i].key, 1, vecs[i].name, 0);
        drive(1, 1, vecs[i].key, 0, vecs[i].name, 0);
      end
      m_l = vecs[i].exp_l; m_r = vecs[i].exp_r;
      drive(1, 0, vecs[i].key, 0, {vecs[i].name, "_rel"}, 0);
    end

    // Esc arrives on the same cycle as a frame tick while W is still the held key.
    drive(1, 1, K_W, 0, "esc_tick_w", 0);
    drive(1, 1, K_W, 0, "esc_tick_w", 0);
    drive(1, 1, K_ESC, 0, "esc_tick_sw", 0);
    m_l = CTR; m_r = CTR;
    drive(1, 1, K_ESC, 1, "esc_tick", 0);
    drive(1, 0, K_ESC, 0, "esc_tick_rel", 0);

    // Pause blocks movement; P held toggles once.
    drive(1, 1, K_P, 0, "pause_on", 0);
    m_p = 1'b1;
    for (int k = 0; k < 4; k++) drive(1, 1, K_P, 0, "pause_hold", 0);
    drive(1, 0, K_P, 0, "pause_rel", 0);
    drive(1, 1, K_W, 0, "paused_w", 0);
    drive(1, 1, K_W, 0, "paused_w", 0);
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, K_W, 1, "paused_w_tick", 0);
      drive(1, 1, K_W, 0, "paused_w_tick", 0);
    end
    drive(1, 0, K_W, 0, "paused_w_rel", 0);
    drive(1, 1, K_P, 0, "pause_off", 0);
    m_p = 1'b0;
    drive(1, 1, K_P, 0, "pause_off", 0);
    drive(1, 0, K_P, 0, "pause_off_rel", 0);

    // Esc clears pause.
    drive(1, 1, K_P, 0, "pause_esc_on", 0);
    m_p = 1'b1;
    drive(1, 0, K_P, 0, "pause_esc_on", 0);
    drive(1, 1, K_ESC, 0, "pause_esc", 0);
    m_p = 1'b0;
    drive(1, 1, K_ESC, 0, "pause_esc", 0);
    drive(1, 0, K_ESC, 0, "pause_esc_rel", 0);

    // Space held for 100 cycles: one serve pulse.
    drive(1, 1, K_SP, 0, "serve", 0);
    drive(1, 1, K_SP, 0, "serve_pulse", 1);
    for (int k = 0; k < 98; k++) drive(1, 1, K_SP, 0, "serve_hold", 0);
    drive(1, 0, K_SP, 0, "serve_rel", 0);

    // Same again while paused: no pulse.
    drive(1, 1, K_P, 0, "serve_p_on", 0);
    m_p = 1'b1;
    drive(1, 0, K_P, 0, "serve_p_on", 0);
    for (int k = 0; k < 100; k++) drive(1, 1, K_SP, 0, "serve_paused", 0);
    drive(1, 0, K_SP, 0, "serve_paused_rel", 0);
    drive(1, 1, K_P, 0, "serve_p_off", 0);
    m_p = 1'b0;
    drive(1, 0, K_P, 0, "serve_p_off", 0);

    // Reset lands on a tick in the middle of an I hold.
    drive(1, 1, K_I, 0, "rst_mid_i", 0);
    drive(1, 1, K_I, 0, "rst_mid_i", 0);
    drive(1, 1, K_I, 0, "rst_mid_i", 0);
    for (int k = 0; k < 3; k++) begin
      m_r = m_r - 4;
      drive(1, 1, K_I, 1, "rst_mid_i_tick", 0);
      drive(1, 1, K_I, 0, "rst_mid_i_tick", 0);
    end
    m_l = CTR; m_r = CTR; m_p = 1'b0;
    drive(0, 1, K_I, 1, "rst_mid_move", 0);
    drive(1, 0, K_I, 0, "rst_mid_after", 0);
    drive(1, 0, 8'h00, 0, "idle_end", 0);

    @(posedge clk);
    #3;
    @(posedge clk);
    #3;
    if (exp_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pong_paddle_ctrl.md
Name: pong_paddle_ctrl

Overview:
- Downstream consumer of the PS/2 keyboard receiver's `ps2_state` / `ps2_byte` pair.
- Turns held-key state into two paddle Y positions for the pong renderer, updated once per video frame.
- Also generates game-control events: serve pulse, pause toggle, and paddle re-centre.
- Sits between the keyboard receiver and the game/ball logic, all on the 50 MHz clock.

Parameters:
- SCREEN_H, 480: visible lines.
- PADDLE_H, 64: paddle height in lines.
- STEP_SLOW, 4: lines moved per frame while key held.
- STEP_FAST, 8: lines per frame after ramp.
- RAMP_FRAMES, 8: number of slow frames before switching to fast.
- Y_W, 10: position width.

Ports:
- clk  in  1  50 MHz system clock
- rst_n  in  1  synchronous active-low reset
- ps2_state  in  1  1 = a key is currently held (from receiver)
- ps2_byte  in  8  make code of the last pressed key
- frame_tick  in  1  one-cycle pulse per video frame
- paddle_l_y  out  Y_W  left paddle top line
- paddle_r_y  out  Y_W  right paddle top line
- paused  out  1  game paused flag
- serve_req  out  1  one-cycle serve pulse

Behaviour:
- Reset (rst_n sampled low on a clk rising edge):
  - paddle_l_y = paddle_r_y = CENTER = (SCREEN_H-PADDLE_H)/2, which is 208 at defaults.
  - paused = 0, serve_req = 0.
  - Internal input registers, key register and hold counter are all cleared.
  - Reset asserted mid-movement takes effect on that edge; no partial update survives it.
- Inputs are registered once (st_q, byte_q). These are same-clock signals; no synchroniser is needed.
- Press event: asserted for one cycle when (st_q rises) OR (st_q=1 and byte_q differs from its previous value).
- Key codes:
  - W 0x1D: left up. S 0x1B: left down.
  - I 0x43: right up. K 0x42: right down.
  - Space 0x29: serve. P 0x4D: pause toggle. Esc 0x76: re-centre.
  - All other codes are ignored.
- Movement key (W/S/I/K) is active while st_q=1 and byte_q equals that code. Only one key can be active, because the upstream block reports a single key.
- On a frame_tick cycle with paused=0 and an active movement key:
  - step = STEP_FAST if hold_cnt >= RAMP_FRAMES, otherwise STEP_SLOW.
  - The selected paddle moves up (subtract) or down (add) by step.
  - The result is computed at Y_W+1 bits and saturated to [0, SCREEN_H-PADDLE_H].
  - hold_cnt increments, saturating at RAMP_FRAMES.
  - The output changes on the clk edge that samples frame_tick, so it is visible the cycle after the tick.
- hold_cnt clears to 0 on:
  - key release (st_q=0),
  - any press event,
  - a frame with paused=1.
- Space press event with paused=0: serve_req=1 for exactly one cycle. Holding the key produces no further pulses.
- P press event: paused toggles. Holding P toggles once only.
- Esc press event: both paddles go to CENTER and paused clears to 0.
- Simultaneous events:
  - Esc press event on the same cycle as frame_tick: Esc wins and no step is applied.
  - Press event on a frame_tick cycle: the new key is evaluated with hold_cnt=0, so it starts at slow speed.
- A paddle already at a bound stays there; no wrap-around occurs.
- Controller states (IDLE, MOVE_SLOW, MOVE_FAST, PAUSED):
  - IDLE to MOVE_SLOW on a movement key.
  - MOVE_SLOW to MOVE_FAST when hold_cnt reaches RAMP_FRAMES.
  - Either MOVE state to IDLE on release or key change; a new key returns to MOVE_SLOW.
  - Any state to PAUSED on a P toggle.
  - PAUSED to IDLE on a P toggle or Esc.

Decomposition:
- Shared package `pong_pkg`:
  - scancode constants (KEY_W, KEY_S, KEY_I, KEY_K, KEY_SPACE, KEY_P, KEY_ESC),
  - the controller state enum,
  - the screen/paddle geometry constants shared with the renderer.
- One natural sub-module: `paddle_axis`. It holds one paddle's position register, saturating add/sub, and hold counter. It is instantiated twice, with up/down/tick/center inputs.

Test Plan:
- Reset: hold rst_n=0 for 2 clk -> paddle_l_y=paddle_r_y=208, paused=0, serve_req=0.
- Hold W (state=1, byte=0x1D) for 3 frame_ticks -> paddle_l_y=196; paddle_r_y stays 208.
- Hold S for 40 frame_ticks:
  - after tick 8 -> 240 (slow);
  - ticks 9 onward add 8;
  - reaches 416 at tick 30 and stays 416 through tick 40.
- Press P, then hold W for 5 ticks -> paused=1, paddle_l_y unchanged. Release, then press P again -> paused=0.
- Hold Space for 100 cycles -> serve_req high exactly 1 cycle. Repeat with paused=1 -> no pulse.
- Left paddle at 0, then Esc press event coincident with frame_tick while byte switches from W -> both 208, paused=0. Then assert rst_n=0 during an I hold -> 208 next edge.
